// File: rtl/reg_file_if.sv
// reg_file_if: bundles the ROB commit port, the flush line and the decoder
// rename/operand-read port of the register file.
//   master : ROB/decoder side (drives commit, flush, rename, operand indices)
//   slave  : register file side (returns operand value/busy/tag)
interface reg_file_if #(
  parameter int REG_NUM_WIDTH  = 5,
  parameter int ROB_SIZE_WIDTH = 5
);
  // ROB commit
  logic                      rob2rf_ready;
  logic [REG_NUM_WIDTH-1:0]  rob2rf_rd;
  logic [31:0]               rob2rf_value;
  logic [ROB_SIZE_WIDTH-1:0] rob2rf_rob_id;
  logic                      need_flush_in;
  // decoder rename + operand read
  logic                      dec_rename_valid;
  logic [REG_NUM_WIDTH-1:0]  dec_rd;
  logic [ROB_SIZE_WIDTH-1:0] dec_rob_id;
  logic [REG_NUM_WIDTH-1:0]  dec_rs1, dec_rs2;
  logic [31:0]               rf2dec_val1, rf2dec_val2;
  logic                      rf2dec_busy1, rf2dec_busy2;
  logic [ROB_SIZE_WIDTH-1:0] rf2dec_tag1, rf2dec_tag2;

  modport master (
    output rob2rf_ready, rob2rf_rd, rob2rf_value, rob2rf_rob_id, need_flush_in,
    output dec_rename_valid, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
    input  rf2dec_val1, rf2dec_val2, rf2dec_busy1, rf2dec_busy2,
    input  rf2dec_tag1, rf2dec_tag2
  );
  modport slave (
    input  rob2rf_ready, rob2rf_rd, rob2rf_value, rob2rf_rob_id, need_flush_in,
    input  dec_rename_valid, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
    output rf2dec_val1, rf2dec_val2, rf2dec_busy1, rf2dec_busy2,
    output rf2dec_tag1, rf2dec_tag2
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: architectural register file with per-register busy bit and ROB
// rename tag. ROB commits write values and release tags; dispatch marks
// destinations busy; a flush clears every busy bit. x0 reads as zero.
// Ports:
//   clk_in   : clock, all state updates on rising edge
//   rst_n_in : synchronous active-low reset (clears values, busy, tags)
//   rdy_in   : global ready, low freezes all state
//   rf       : reg_file_if slave (commit, flush, rename, two read ports)
module reg_file #(
  parameter int REG_NUM_WIDTH  = 5,
  parameter int ROB_SIZE_WIDTH = 5
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  logic      rdy_in,
  reg_file_if.slave rf
);
  localparam int NREG   = 1 << REG_NUM_WIDTH;
  localparam int NPORTS = 2;

  logic [NREG-1:0][31:0]               val_q, val_d;
  logic [NREG-1:0]                     busy_q, busy_d;
  logic [NREG-1:0][ROB_SIZE_WIDTH-1:0] tag_q, tag_d;

  logic commit_v, rename_v;
  assign commit_v = rf.rob2rf_ready && (rf.rob2rf_rd != '0);
  assign rename_v = rf.dec_rename_valid && (rf.dec_rd != '0);

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      if (commit_v) begin
        val_d[rf.rob2rf_rd] = rf.rob2rf_value;
        // A tag mismatch means a younger producer still owns rd.
        if (busy_q[rf.rob2rf_rd] && tag_q[rf.rob2rf_rd] == rf.rob2rf_rob_id)
          busy_d[rf.rob2rf_rd] = 1'b0;
      end
      // Flush keeps the commit write (mispredicted JALR commits and flushes
      // together) but drops the rename; otherwise rename overrides commit.
      if (rf.need_flush_in) begin
        busy_d = '0;
      end else if (rename_v) begin
        busy_d[rf.dec_rd] = 1'b1;
        tag_d[rf.dec_rd]  = rf.dec_rob_id;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Read ports. Forwarding only looks at the commit bus, never at the
  // same-cycle rename, so a dispatch never sees its own destination.
  logic [NPORTS-1:0][REG_NUM_WIDTH-1:0]  rs;
  logic [NPORTS-1:0][31:0]               rd_val;
  logic [NPORTS-1:0]                     rd_busy;
  logic [NPORTS-1:0][ROB_SIZE_WIDTH-1:0] rd_tag;

  assign rs[0] = rf.dec_rs1;
  assign rs[1] = rf.dec_rs2;

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    always_comb begin
      rd_val[p]  = '0;
      rd_busy[p] = 1'b0;
      rd_tag[p]  = '0;
      if (rs[p] != '0) begin
        rd_val[p]  = val_q[rs[p]];
        rd_busy[p] = busy_q[rs[p]];
        rd_tag[p]  = tag_q[rs[p]];
        if (busy_q[rs[p]] && rf.rob2rf_ready && rf.rob2rf_rd == rs[p] &&
            rf.rob2rf_rob_id == tag_q[rs[p]]) begin
          rd_val[p]  = rf.rob2rf_value;
          rd_busy[p] = 1'b0;
        end
      end
    end
  end

  assign rf.rf2dec_val1  = rd_val[0];
  assign rf.rf2dec_val2  = rd_val[1];
  assign rf.rf2dec_busy1 = rd_busy[0];
  assign rf.rf2dec_busy2 = rd_busy[1];
  assign rf.rf2dec_tag1  = rd_tag[0];
  assign rf.rf2dec_tag2  = rd_tag[1];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed test-plan scenarios followed by randomized traffic,
// all checked against an array-based model of the register file rules.
module tb_reg_file;
  logic gclk = 1'b0;
  logic rst_n, rdy;
  int total = 0, bad = 0;

  always #5 gclk = ~gclk;

  reg_file_if #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) rf ();

  reg_file #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) dut (
    .clk_in(gclk), .rst_n_in(rst_n), .rdy_in(rdy), .rf(rf)
  );

  // reference state
  logic [31:0] mval [32];
  bit          mbusy[32];
  logic [4:0]  mtag [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rf.rob2rf_ready = 0; rf.rob2rf_rd = 0; rf.rob2rf_value = 0; rf.rob2rf_rob_id = 0;
    rf.need_flush_in = 0; rf.dec_rename_valid = 0; rf.dec_rd = 0; rf.dec_rob_id = 0;
  endtask

  // expected read of one operand, from the model plus the commit bus
  task automatic model_rd(input int r, output logic [31:0] v, output bit b, output logic [4:0] t);
    v = 0; b = 0; t = 0;
    if (r != 0) begin
      v = mval[r]; b = mbusy[r]; t = mtag[r];
      if (b && rf.rob2rf_ready && int'(rf.rob2rf_rd) == r && rf.rob2rf_rob_id == t) begin
        v = rf.rob2rf_value; b = 0;
      end
    end
  endtask

  task automatic chk_port(input string nm, input int r, input logic [31:0] v,
                          input logic b, input logic [4:0] t);
    logic [31:0] ev; bit eb; logic [4:0] et;
    model_rd(r, ev, eb, et);
    chk({nm, "_val"}, v, ev);
    chk({nm, "_busy"}, {31'b0, b}, {31'b0, eb});
    if (eb) chk({nm, "_tag"}, {27'b0, t}, {27'b0, et});
  endtask

  // one clock: check reads mid-cycle (skipped while reset is asserted),
  // then apply the same inputs to the model at the edge
  task automatic cyc();
    int crd, rrd;
    @(negedge gclk);
    if (rst_n) begin
      chk_port("p1", int'(rf.dec_rs1), rf.rf2dec_val1, rf.rf2dec_busy1, rf.rf2dec_tag1);
      chk_port("p2", int'(rf.dec_rs2), rf.rf2dec_val2, rf.rf2dec_busy2, rf.rf2dec_tag2);
    end
    @(posedge gclk);
    crd = int'(rf.rob2rf_rd); rrd = int'(rf.dec_rd);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin mval[i] = 0; mbusy[i] = 0; mtag[i] = 0; end
    end else if (rdy) begin
      if (rf.rob2rf_ready && crd != 0) begin
        mval[crd] = rf.rob2rf_value;
        if (mbusy[crd] && mtag[crd] == rf.rob2rf_rob_id) mbusy[crd] = 0;
      end
      if (rf.need_flush_in) for (int i = 0; i < 32; i++) mbusy[i] = 0;
      else if (rf.dec_rename_valid && rrd != 0) begin
        mbusy[rrd] = 1; mtag[rrd] = rf.dec_rob_id;
      end
    end
    #1;
  endtask

  task automatic commit(input int rd, input int id, input logic [31:0] v);
    rf.rob2rf_ready = 1; rf.rob2rf_rd = 5'(rd); rf.rob2rf_rob_id = 5'(id); rf.rob2rf_value = v;
  endtask

  task automatic rename(input int rd, input int id);
    rf.dec_rename_valid = 1; rf.dec_rd = 5'(rd); rf.dec_rob_id = 5'(id);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mval[i] = 0; mbusy[i] = 0; mtag[i] = 0; end
    idle(); rf.dec_rs1 = 0; rf.dec_rs2 = 0;
    rst_n = 0; rdy = 1;
    cyc(); cyc();
    rst_n = 1;

    // reset state and x0 behaviour
    rf.dec_rs1 = 5; #1;
    chk("rst_val", rf.rf2dec_val1, 0);
    chk("rst_busy", {31'b0, rf.rf2dec_busy1}, 0);
    commit(0, 0, 32'hDEAD); cyc();
    idle(); rf.dec_rs1 = 0; #1;
    chk("x0_val", rf.rf2dec_val1, 0);
    chk("x0_busy", {31'b0, rf.rf2dec_busy1}, 0);

    // rename then forwarded commit
    rename(3, 7); cyc();
    idle(); rf.dec_rs2 = 3; #1;
    chk("x3_busy", {31'b0, rf.rf2dec_busy2}, 1);
    chk("x3_tag", {27'b0, rf.rf2dec_tag2}, 7);
    commit(3, 7, 32'h1234); #1;
    chk("x3_fwd_val", rf.rf2dec_val2, 32'h1234);
    chk("x3_fwd_busy", {31'b0, rf.rf2dec_busy2}, 0);
    cyc(); idle(); #1;
    chk("x3_val", rf.rf2dec_val2, 32'h1234);
    chk("x3_busy2", {31'b0, rf.rf2dec_busy2}, 0);

    // stale commit keeps younger producer
    rename(4, 2); cyc();
    rename(4, 9); cyc();
    idle(); commit(4, 2, 32'h55); cyc();
    idle(); rf.dec_rs1 = 4; #1;
    chk("x4_val", rf.rf2dec_val1, 32'h55);
    chk("x4_busy", {31'b0, rf.rf2dec_busy1}, 1);
    chk("x4_tag", {27'b0, rf.rf2dec_tag1}, 9);

    // commit and rename same rd
    rename(6, 1); cyc();
    commit(6, 1, 32'hAA); rename(6, 4); cyc();
    idle(); rf.dec_rs1 = 6; #1;
    chk("x6_val", rf.rf2dec_val1, 32'hAA);
    chk("x6_busy", {31'b0, rf.rf2dec_busy1}, 1);
    chk("x6_tag", {27'b0, rf.rf2dec_tag1}, 4);

    // flush with same-cycle commit and dropped rename
    rename(1, 3); cyc();
    rename(2, 4); cyc();
    rename(31, 5); cyc();
    idle(); rf.need_flush_in = 1; commit(1, 3, 32'h77); rename(8, 6); cyc();
    idle(); rf.dec_rs1 = 1; rf.dec_rs2 = 8; #1;
    chk("fl_x1_val", rf.rf2dec_val1, 32'h77);
    chk("fl_x1_busy", {31'b0, rf.rf2dec_busy1}, 0);
    chk("fl_x8_busy", {31'b0, rf.rf2dec_busy2}, 0);
    rf.dec_rs1 = 2; rf.dec_rs2 = 31; #1;
    chk("fl_x2_busy", {31'b0, rf.rf2dec_busy1}, 0);
    chk("fl_x31_busy", {31'b0, rf.rf2dec_busy2}, 0);
    rf.dec_rs1 = 4; #1;
    chk("fl_x4_busy", {31'b0, rf.rf2dec_busy1}, 0);

    // freeze, then reset mid-sequence
    rename(10, 1); cyc();
    idle(); rdy = 0; commit(10, 1, 32'h99); cyc(); cyc();
    rdy = 1; idle(); rf.dec_rs1 = 10; #1;
    chk("frz_val", rf.rf2dec_val1, 0);
    chk("frz_busy", {31'b0, rf.rf2dec_busy1}, 1);
    chk("frz_tag", {27'b0, rf.rf2dec_tag1}, 1);
    rst_n = 0; commit(10, 1, 32'h99); rename(12, 3); cyc();
    rst_n = 1; idle(); rf.dec_rs1 = 10; rf.dec_rs2 = 6; #1;
    chk("rst2_busy", {31'b0, rf.rf2dec_busy1}, 0);
    chk("rst2_val10", rf.rf2dec_val1, 0);
    chk("rst2_val6", rf.rf2dec_val2, 0);

    // randomized traffic on a narrow register window to force collisions
    for (int n = 0; n < 600; n++) begin
      int crd;
      idle();
      rst_n = ($urandom_range(0, 99) != 0);
      rdy   = ($urandom_range(0, 9) != 0);
      crd   = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1)
        commit(crd, ($urandom_range(0, 2) != 0) ? int'(mtag[crd]) : $urandom_range(0, 31),
               $urandom());
      if ($urandom_range(0, 1) == 1) rename($urandom_range(0, 7), $urandom_range(0, 31));
      rf.need_flush_in = ($urandom_range(0, 19) == 0);
      rf.dec_rs1 = 5'($urandom_range(0, 7));
      rf.dec_rs2 = ($urandom_range(0, 1) == 1) ? rf.rob2rf_rd : 5'($urandom_range(0, 7));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags. It sits directly downstream of the reorder buffer's commit port and upstream of issue.
- Holds 32 x 32-bit registers. Each register has a busy bit and a ROB-id tag naming its pending producer.
- The decoder reads operands and tags from it and marks destinations busy at dispatch. ROB commits write values and release tags.
- A mispredict flush clears every busy bit. Committed values are never rolled back.

Parameters:
- REG_NUM_WIDTH, 5, register index width (32 registers).
- ROB_SIZE_WIDTH, 5, ROB entry id width; must match the ROB.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  reset.
- rdy_in  input  1  global ready; low = freeze all state.
- rob2rf_ready  input  1  commit valid.
- rob2rf_rd  input  REG_NUM_WIDTH  commit destination register.
- rob2rf_value  input  32  commit value.
- rob2rf_rob_id  input  ROB_SIZE_WIDTH  ROB id of the committing entry.
- need_flush_in  input  1  flush; driven by the ROB flush output.
- dec_rename_valid  input  1  dispatch claims a destination this cycle.
- dec_rd  input  REG_NUM_WIDTH  dispatched destination register.
- dec_rob_id  input  ROB_SIZE_WIDTH  ROB id allocated to the dispatched instruction.
- dec_rs1, dec_rs2  input  REG_NUM_WIDTH  operand register indices.
- rf2dec_val1, rf2dec_val2  output  32  operand values.
- rf2dec_busy1, rf2dec_busy2  output  1  1 = operand pending in the ROB.
- rf2dec_tag1, rf2dec_tag2  output  ROB_SIZE_WIDTH  ROB id of the pending producer; valid only when busy.

Behaviour:
- Reset is synchronous, active-low: rst_n_in low at a rising clk_in edge sets all values to 0, all busy bits to 0 and all tags to 0. Reset overrides rdy_in, flush, commit and rename.
- Read outputs are combinational from state, so they read 0 / 0 / 0 while and immediately after reset.
- rdy_in low (not in reset): no state change. Combinational reads still function.
- Register x0:
  - Reads always return value 0, busy 0, tag 0.
  - Commits and renames targeting x0 are ignored.
- Commit (rob2rf_ready=1, rd!=0):
  - value[rd] <= rob2rf_value, written unconditionally.
  - Busy[rd] is cleared only if busy[rd]=1 and tag[rd]==rob2rf_rob_id. A tag mismatch means a younger producer owns rd, so busy and tag are kept.
- Rename (dec_rename_valid=1, rd!=0, no flush): busy[dec_rd] <= 1, tag[dec_rd] <= dec_rob_id.
- Commit and rename to the same rd in the same cycle: the value is written and rename wins (busy=1, tag=dec_rob_id).
- Flush (need_flush_in=1):
  - The same-cycle commit write is still applied, because the ROB asserts commit and flush together for a mispredicted JALR.
  - All 32 busy bits clear; tags become don't-care.
  - A same-cycle rename is dropped.
- Read forwarding (combinational, per operand port), for a nonzero rs that is busy:
  - If rob2rf_ready=1, rob2rf_rd==rs and rob2rf_rob_id==tag[rs], output val=rob2rf_value, busy=0.
  - Forwarding ignores same-cycle rename, so the decoder's own destination is never visible to its own operand read.
  - Otherwise output val=value[rs], busy=busy[rs], tag=tag[rs].
- Latency: commit and rename take effect at the next edge; reads are zero-cycle.
- No internal handshake or backpressure; every input is consumed the cycle it is valid.

Test Plan:
- Reset then release, read rs1=5 -> val 0, busy 0; write x0 via commit value 0xDEAD, read rs1=0 -> 0, busy 0.
- Rename x3 with tag 7, next cycle read rs2=3 -> busy 1, tag 7.
  - Commit rd=3, id=7, value 0x1234 -> same-cycle read shows val 0x1234, busy 0 (forwarded).
  - Next cycle: stored val 0x1234, busy 0.
- Rename x4 tag 2, then rename x4 tag 9, then commit rd=4 id=2 value 0x55 -> val 0x55, busy 1, tag 9 retained.
- Same cycle: commit rd=6 id=1 value 0xAA and rename rd=6 tag 4 (x6 previously tagged 1) -> val 0xAA, busy 1, tag 4.
- Rename x1, x2, x31 (tags 3, 4, 5), then one cycle with need_flush_in=1 plus commit rd=1 id=3 value 0x77 and rename rd=8 tag 6:
  - After the edge: x1=0x77; busy x1, x2, x31 and x8 all 0.
- Rename x10 tag 1, hold rdy_in=0 while asserting commit rd=10 id=1 -> x10 unchanged and busy.
  - Assert rst_n_in=0 mid-sequence -> next edge all busy 0 and values 0.
